led_pattern_sequencer: RTL and testbench

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

---
 rtl/led_seq_pkg.sv | 36 +++
 rtl/led_pattern_sequencer_key_debounce.sv | 55 +++++
 rtl/led_pattern_sequencer.sv | 160 ++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: pattern modes, per-mode seeds,
// PIO register address and the Avalon write FSM states.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_WALK   = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  localparam logic [7:0] SEED_WALK   = 8'h01;
  localparam logic [7:0] SEED_COUNT  = 8'h00;
  localparam logic [7:0] SEED_BLINK  = 8'h00;
  localparam logic [7:0] SEED_BOUNCE = 8'h01;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_WRITE = 1'b1
  } wr_state_e;

  function automatic logic [7:0] mode_seed(input mode_e m);
    logic [7:0] seed;
    case (m)
      MODE_WALK:   seed = SEED_WALK;
      MODE_COUNT:  seed = SEED_COUNT;
      MODE_BLINK:  seed = SEED_BLINK;
      MODE_BOUNCE: seed = SEED_BOUNCE;
      default:     seed = SEED_WALK;
    endcase
    return seed;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_key_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability debouncer and a
// one-cycle press pulse on the accepted released->pressed transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Down-counter reloads whenever the synced input agrees with the accepted level.
  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = CNT_LOAD;
    if (sync2_q != stable_q) begin
      if (cnt_q == '0) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    press_d = stable_q & ~stable_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= CNT_LOAD;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Key-driven LED pattern generator that pushes every new pattern to an
// Avalon-MM LED PIO slave through a single-outstanding write FSM.
//
// state    | meaning
// WR_IDLE  | bus idle; launches a write when a pattern change is pending
// WR_WRITE | write asserted; held until avm_waitrequest is low
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int STEP_CYCLES     = 12500000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  key_n,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic [1:0]  mode,
  output logic        paused
);

  localparam int SW          = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int FAST_CYCLES = (STEP_CYCLES / 4 > 0) ? STEP_CYCLES / 4 : 1;
  localparam logic [SW-1:0] LAST_NORM = SW'(STEP_CYCLES - 1);
  localparam logic [SW-1:0] LAST_FAST = SW'(FAST_CYCLES - 1);

  logic [3:0] press;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk  (clk),
      .reset(reset),
      .key_n(key_n[i]),
      .press(press[i])
    );
  end

  mode_e         mode_q, mode_d;
  logic [7:0]    pattern_q, pattern_d;
  logic          dir_left_q, dir_left_d;
  logic          paused_q, paused_d;
  logic          fast_q, fast_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  wr_state_e     wr_state_q, wr_state_d;
  logic          wr_pending_q, wr_pending_d;
  logic [31:0]   wdata_q, wdata_d;

  logic [SW-1:0] step_last;
  logic          tick;
  logic          key_act;
  logic          pat_chg;
  logic [7:0]    step_pat;
  logic          step_dir;

  always_comb begin
    step_pat = pattern_q;
    step_dir = dir_left_q;
    case (mode_q)
      MODE_WALK:  step_pat = {pattern_q[6:0], pattern_q[7]};
      MODE_COUNT: step_pat = pattern_q + 8'd1;
      MODE_BLINK: step_pat = ~pattern_q;
      MODE_BOUNCE: begin
        if (dir_left_q) begin
          step_pat = pattern_q << 1;
          if (step_pat == 8'h80) step_dir = 1'b0;
        end else begin
          step_pat = pattern_q >> 1;
          if (step_pat == 8'h01) step_dir = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Any effective key press wins over a same-cycle tick; Key3 only counts while paused.
  always_comb begin
    step_last  = fast_q ? LAST_FAST : LAST_NORM;
    tick       = !paused_q && (step_cnt_q >= step_last);
    key_act    = press[0] | press[1] | press[2];
    mode_d     = mode_q;
    pattern_d  = pattern_q;
    dir_left_d = dir_left_q;
    paused_d   = paused_q ^ press[1];
    fast_d     = fast_q ^ press[2];
    step_cnt_d = step_cnt_q;
    pat_chg    = 1'b0;
    if (!paused_q) begin
      step_cnt_d = tick ? '0 : step_cnt_q + 1'b1;
    end
    if (press[0]) begin
      mode_d     = mode_e'(mode_q + 2'd1);
      pattern_d  = mode_seed(mode_d);
      dir_left_d = 1'b1;
      step_cnt_d = '0;
      pat_chg    = 1'b1;
    end else if ((press[3] && paused_q) || (tick && !key_act)) begin
      pattern_d  = step_pat;
      dir_left_d = step_dir;
      pat_chg    = 1'b1;
    end
  end

  always_comb begin
    wr_state_d   = wr_state_q;
    wdata_d      = wdata_q;
    wr_pending_d = wr_pending_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (wr_pending_q) begin
          wr_state_d   = WR_WRITE;
          wdata_d      = {24'b0, pattern_q};
          wr_pending_d = 1'b0;
        end
      end
      WR_WRITE: begin
        if (!avm_waitrequest) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
    // A change in the latch cycle keeps the flag so the newer pattern follows.
    if (pat_chg) wr_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= MODE_WALK;
      pattern_q    <= SEED_WALK;
      dir_left_q   <= 1'b1;
      paused_q     <= 1'b0;
      fast_q       <= 1'b0;
      step_cnt_q   <= '0;
      wr_state_q   <= WR_IDLE;
      wr_pending_q <= 1'b1;
      wdata_q      <= '0;
    end else begin
      mode_q       <= mode_d;
      pattern_q    <= pattern_d;
      dir_left_q   <= dir_left_d;
      paused_q     <= paused_d;
      fast_q       <= fast_d;
      step_cnt_q   <= step_cnt_d;
      wr_state_q   <= wr_state_d;
      wr_pending_q <= wr_pending_d;
      wdata_q      <= wdata_d;
    end
  end

  assign avm_chipselect = (wr_state_q == WR_WRITE);
  assign avm_write_n    = (wr_state_q != WR_WRITE);
  assign avm_address    = PIO_DATA_ADDR;
  assign avm_writedata  = wdata_q;
  assign mode           = mode_q;
  assign paused         = paused_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: behavioural pattern/key model checked every
// cycle, plus hand-computed write sequences for the directed scenarios.
module tb_led_pattern_sequencer;

  localparam int STEP = 8;
  localparam int DEB  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  key_n = 4'hF;
  logic        avm_waitrequest = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [1:0]  mode;
  logic        paused;

  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .STEP_CYCLES(STEP),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .key_n          (key_n),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .mode           (mode),
    .paused         (paused)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int m_mode, m_pat, m_pos, m_dirl, m_paused, m_fast, m_cnt;
  int m_dirty;
  logic [31:0] m_wdata;
  int lvl[4], run[4], eff_in[4];
  int prev_cs;
  int wr_log[$];

  function automatic logic [31:0] log_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Inputs only change 2ns after a negedge, so values seen here are those
  // the DUT sampled at the preceding posedge.
  always @(negedge clk) begin
    int eff[4];
    int pat_before, dirty_before, changed, tick, start, limit;
    if (reset) begin
      m_mode = 0; m_pat = 1; m_pos = 0; m_dirl = 1;
      m_paused = 0; m_fast = 0; m_cnt = 0; m_dirty = 1; m_wdata = '0;
      for (int i = 0; i < 4; i++) begin lvl[i] = 1; run[i] = 0; eff_in[i] = 0; end
      prev_cs = 0;
      chk("rst_cs", {31'b0, avm_chipselect}, 32'd0);
      chk("rst_write_n", {31'b0, avm_write_n}, 32'd1);
      chk("rst_addr", {30'b0, avm_address}, 32'd0);
      chk("rst_data", avm_writedata, 32'd0);
      chk("rst_mode", {30'b0, mode}, 32'd0);
      chk("rst_paused", {31'b0, paused}, 32'd0);
    end else begin
      pat_before = m_pat;
      dirty_before = m_dirty;
      // A key level is accepted after DEB consecutive differing samples;
      // the press acts three edges after the last of them.
      for (int i = 0; i < 4; i++) begin
        eff[i] = (eff_in[i] == 1) ? 1 : 0;
        if (eff_in[i] > 0) eff_in[i]--;
        if (int'(key_n[i]) != lvl[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            lvl[i] = int'(key_n[i]);
            run[i] = 0;
            if (lvl[i] == 0) eff_in[i] = 3;
          end
        end else begin
          run[i] = 0;
        end
      end
      limit = (m_fast != 0) ? STEP / 4 : STEP;
      tick = (m_paused == 0 && m_cnt >= limit - 1) ? 1 : 0;
      if (eff[0] != 0) m_cnt = 0;
      else if (m_paused == 0) m_cnt = (tick != 0) ? 0 : m_cnt + 1;
      changed = 0;
      if (eff[0] != 0) begin
        m_mode = (m_mode + 1) % 4;
        m_pat = (m_mode == 0 || m_mode == 3) ? 1 : 0;
        m_pos = 0; m_dirl = 1; changed = 1;
      end else if ((eff[3] != 0 && m_paused != 0) ||
                   (tick != 0 && eff[1] == 0 && eff[2] == 0)) begin
        changed = 1;
        case (m_mode)
          0: m_pat = (m_pat == 128) ? 1 : m_pat * 2;
          1: m_pat = (m_pat + 1) % 256;
          2: m_pat = 255 - m_pat;
          default: begin
            if (m_dirl != 0) begin m_pos++; if (m_pos == 7) m_dirl = 0; end
            else begin m_pos--; if (m_pos == 0) m_dirl = 1; end
            m_pat = 1 << m_pos;
          end
        endcase
      end
      if (eff[1] != 0) m_paused = 1 - m_paused;
      if (eff[2] != 0) m_fast = 1 - m_fast;

      start = 0;
      chk("addr", {30'b0, avm_address}, 32'd0);
      chk("write_n_vs_cs", {31'b0, avm_write_n}, {31'b0, ~avm_chipselect});
      if (prev_cs != 0) begin
        if (avm_waitrequest) begin
          chk("stall_cs", {31'b0, avm_chipselect}, 32'd1);
        end else begin
          chk("done_cs", {31'b0, avm_chipselect}, 32'd0);
          wr_log.push_back(m_wdata);
        end
      end else if (avm_chipselect) begin
        chk("start_pending", dirty_before, 32'd1);
        m_wdata = pat_before;
        start = 1;
      end else if (dirty_before != 0) begin
        chk("write_launch", {31'b0, avm_chipselect}, 32'd1);
      end
      chk("wdata", avm_writedata, m_wdata);
      chk("mode", {30'b0, mode}, m_mode);
      chk("paused", {31'b0, paused}, m_paused);
      m_dirty = (changed != 0 || (dirty_before != 0 && start == 0)) ? 1 : 0;
      prev_cs = avm_chipselect ? 1 : 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
  endtask

  task automatic press(input int k);
    key_n[k] = 1'b0;
    step(6);
    key_n[k] = 1'b1;
    step(6);
  endtask

  task automatic chk_log(input string name, input int n, input int exp_v[]);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s[%0d]", name, i), log_at(i), exp_v[i]);
  endtask

  initial begin
    int exp_walk[]   = '{1, 2, 4, 8, 16, 32, 64, 128, 1, 2};
    int exp_key0[]   = '{1, 0, 1, 2};
    int exp_stall[]  = '{1, 4};
    int exp_bounce[] = '{2, 4, 8, 16, 32, 64, 128, 64, 32, 16, 8, 4, 2, 1, 2};
    int exp_coinc[]  = '{1, 2, 0, 1};

    // Walk from reset: 0x01 write, then a step every 8 cycles, 0x80 wraps to 0x01
    do_reset();
    wr_log.delete();
    step(75);
    chk("walk_count", wr_log.size(), 10);
    chk_log("walk", 10, exp_walk);

    // Key0 held 6 cycles -> count mode; short bounce ignored
    do_reset();
    wr_log.delete();
    key_n[0] = 1'b0;
    step(6);
    key_n[0] = 1'b1;
    step(20);
    chk("key0_count", wr_log.size(), 4);
    chk_log("key0", 4, exp_key0);
    chk("key0_mode", {30'b0, mode}, 32'd1);
    key_n[0] = 1'b0;
    step(3);
    key_n[0] = 1'b1;
    step(10);
    chk("bounce_mode", {30'b0, mode}, 32'd1);

    // Long stall with two ticks -> one coalesced follow-up write
    avm_waitrequest = 1'b1;
    do_reset();
    wr_log.delete();
    step(20);
    chk("stall_cs_held", {31'b0, avm_chipselect}, 32'd1);
    chk("stall_data_held", avm_writedata, 32'd1);
    avm_waitrequest = 1'b0;
    step(3);
    chk("stall_count", wr_log.size(), 2);
    chk_log("stall", 2, exp_stall);

    // Bounce mode: pause, select mode 3, resume, then pause and single step
    do_reset();
    press(1);
    press(0);
    press(0);
    press(0);
    chk("bounce_sel_mode", {30'b0, mode}, 32'd3);
    wr_log.delete();
    press(1);
    step(118);
    chk("bnc_count", wr_log.size(), 15);
    chk_log("bnc", 15, exp_bounce);
    press(1);
    wr_log.delete();
    step(30);
    chk("paused_no_write", wr_log.size(), 0);
    chk("paused_flag", {31'b0, paused}, 32'd1);
    press(3);
    step(10);
    chk("manual_count", wr_log.size(), 1);
    chk("manual_data", log_at(0), 32'h08);

    // Keys 0,1,3 together while paused: reload wins over step, pause toggles
    wr_log.delete();
    key_n = 4'b0100;
    step(6);
    key_n = 4'hF;
    step(4);
    chk("multi_count", wr_log.size(), 1);
    chk("multi_data", log_at(0), 32'h01);
    chk("multi_mode", {30'b0, mode}, 32'd0);
    chk("multi_paused", {31'b0, paused}, 32'd0);
    press(2);
    press(3);
    step(20);
    press(2);

    // Key0 press landing on a tick: seed written, tick dropped
    do_reset();
    wr_log.delete();
    step(9);
    key_n[0] = 1'b0;
    step(6);
    key_n[0] = 1'b1;
    step(10);
    chk("coinc_count", wr_log.size(), 3);
    step(2);
    chk_log("coinc", 4, exp_coinc);
    chk("coinc_mode", {30'b0, mode}, 32'd1);

    // Reset during a stalled write
    avm_waitrequest = 1'b1;
    step(8);
    chk("pre_rst_cs", {31'b0, avm_chipselect}, 32'd1);
    reset = 1'b1;
    step(1);
    chk("abort_cs", {31'b0, avm_chipselect}, 32'd0);
    chk("abort_write_n", {31'b0, avm_write_n}, 32'd1);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    wr_log.delete();
    step(3);
    chk("post_rst_count", wr_log.size(), 1);
    chk("post_rst_data", log_at(0), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
